// File: rtl/bscan_counter_reader.sv
// bscan_counter_reader: JTAG-side initiator for the BSCAN counter readback protocol.
// It walks the decoded TAP strobes through an init sequence that loads USER4, then
// runs one command scan (counter select) and one readback scan per request.
// All outputs are registered from the next-state decode, so they change on posedge tck.
module bscan_counter_reader #(
    parameter int                   IR_LENGTH       = 6,
    parameter int                   CMD_WIDTH       = 4,
    parameter logic [CMD_WIDTH-1:0] COUNTER_SEL_CMD = 4'b1001,
    parameter int                   SEL_WIDTH       = 3,
    parameter int                   READBACK_WIDTH  = 32
) (
    input  logic                      tck,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SEL_WIDTH-1:0]      req_sel,
    output logic                      rsp_valid,
    output logic [READBACK_WIDTH-1:0] rsp_data,
    output logic                      busy,
    output logic                      tdi,
    input  logic                      tdo,
    output logic                      test_logic_reset,
    output logic                      run_test_idle,
    output logic                      ir_is_user,
    output logic                      capture_dr,
    output logic                      shift_dr,
    output logic                      update_dr
);

    localparam int CMD_LEN  = CMD_WIDTH + 1 + SEL_WIDTH;
    localparam int BIT_W    = $clog2(CMD_LEN);
    localparam int RB_W     = $clog2(READBACK_WIDTH);
    localparam int IR_CYC   = IR_LENGTH + 4;
    localparam int IR_W     = $clog2(IR_CYC);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CMD_LEN - 1);
    localparam logic [RB_W-1:0]  RB_LAST  = RB_W'(READBACK_WIDTH - 1);
    localparam logic [IR_W-1:0]  IR_LAST  = IR_W'(IR_CYC - 1);

    typedef enum logic [4:0] {
        S_TLR, S_INIT_RTI, S_SEL, S_IR, S_IDLE,
        S_C_SEL, S_C_CAP, S_C_SH, S_C_EX1, S_C_UPD, S_C_RTI1, S_C_RTI2,
        S_R_SEL, S_R_CAP, S_R_SH, S_R_EX1, S_R_UPD
    } state_t;

    state_t                    state_reg, state_next;
    logic [IR_W-1:0]           ir_cnt_reg;
    logic [BIT_W-1:0]          bit_idx_reg;
    logic [RB_W-1:0]           rb_idx_reg;
    logic [CMD_LEN-1:0]        cmd_reg;
    logic [READBACK_WIDTH-1:0] cap_reg;
    logic                      tdi_next;

    // State register
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) state_reg <= S_TLR;
        else        state_reg <= state_next;
    end

    // Next-state sequencing; req_valid only matters in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_TLR:      state_next = S_INIT_RTI;
            S_INIT_RTI: state_next = S_SEL;
            S_SEL:      state_next = S_IR;
            S_IR:       if (ir_cnt_reg == IR_LAST) state_next = S_IDLE;
            S_IDLE:     if (req_valid) state_next = S_C_SEL;
            S_C_SEL:    state_next = S_C_CAP;
            S_C_CAP:    state_next = S_C_SH;
            S_C_SH:     if (bit_idx_reg == BIT_LAST) state_next = S_C_EX1;
            S_C_EX1:    state_next = S_C_UPD;
            S_C_UPD:    state_next = S_C_RTI1;
            S_C_RTI1:   state_next = S_C_RTI2;
            S_C_RTI2:   state_next = S_R_SEL;
            S_R_SEL:    state_next = S_R_CAP;
            S_R_CAP:    state_next = S_R_SH;
            S_R_SH:     if (rb_idx_reg == RB_LAST) state_next = S_R_EX1;
            S_R_EX1:    state_next = S_R_UPD;
            S_R_UPD:    state_next = S_IDLE;
            default:    state_next = S_TLR;
        endcase
    end

    // Command bit for the upcoming shift cycle: bit 0 on entry, then the following bit
    always_comb begin
        tdi_next = 1'b0;
        if (state_next == S_C_SH) begin
            if (state_reg == S_C_SH) tdi_next = cmd_reg[bit_idx_reg + 1'b1];
            else                     tdi_next = cmd_reg[0];
        end
    end

    // Cycle counters; each sits at zero outside its state, so it is clear on entry
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            ir_cnt_reg  <= '0;
            bit_idx_reg <= '0;
            rb_idx_reg  <= '0;
        end else begin
            ir_cnt_reg  <= (state_reg == S_IR)   ? ir_cnt_reg + 1'b1  : '0;
            bit_idx_reg <= (state_reg == S_C_SH) ? bit_idx_reg + 1'b1 : '0;
            rb_idx_reg  <= (state_reg == S_R_SH) ? rb_idx_reg + 1'b1  : '0;
        end
    end

    // Latch the select command at accept so later req_sel changes are ignored
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n)                              cmd_reg <= '0;
        else if (state_reg == S_IDLE && req_valid) cmd_reg <= {COUNTER_SEL_CMD, 1'b0, req_sel};
    end

    // Capture buffer: each bit takes tdo at the edge ending its shift cycle
    for (genvar gi = 0; gi < READBACK_WIDTH; gi++) begin : g_cap
        always_ff @(posedge tck or negedge rst_n) begin
            if (!rst_n)
                cap_reg[gi] <= 1'b0;
            else if (state_reg == S_R_SH && rb_idx_reg == RB_W'(gi))
                cap_reg[gi] <= tdo;
        end
    end

    // Publish the captured word together with the rsp_valid pulse
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= (state_reg == S_R_UPD);
            if (state_reg == S_R_UPD) rsp_data <= cap_reg;
        end
    end

    // Registered strobes and handshake decoded from the state being entered
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            test_logic_reset <= 1'b1;
            run_test_idle    <= 1'b0;
            capture_dr       <= 1'b0;
            shift_dr         <= 1'b0;
            update_dr        <= 1'b0;
            ir_is_user       <= 1'b0;
            req_ready        <= 1'b0;
            busy             <= 1'b1;
            tdi              <= 1'b0;
        end else begin
            test_logic_reset <= (state_next == S_TLR);
            run_test_idle    <= (state_next == S_INIT_RTI) || (state_next == S_IDLE) ||
                                (state_next == S_C_RTI1) || (state_next == S_C_RTI2);
            capture_dr       <= (state_next == S_C_CAP) || (state_next == S_R_CAP);
            shift_dr         <= (state_next == S_C_SH) || (state_next == S_R_SH);
            update_dr        <= (state_next == S_C_UPD) || (state_next == S_R_UPD);
            ir_is_user       <= ir_is_user || (state_next == S_IDLE);
            req_ready        <= (state_next == S_IDLE);
            busy             <= (state_next != S_IDLE);
            tdi              <= tdi_next;
        end
    end

endmodule

// File: tb/tb_bscan_counter_reader.sv
// Testbench for bscan_counter_reader: a responder model plays the user logic
// (records tdi during the command scan, drives tdo during the readback scan),
// and a negedge monitor pops expected commands/responses from scoreboard queues.
module tb_bscan_counter_reader;

    logic        tck = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sel;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tdi;
    logic        tdo = 1'b0;
    logic        test_logic_reset, run_test_idle, ir_is_user;
    logic        capture_dr, shift_dr, update_dr;

    bscan_counter_reader dut (
        .tck(tck), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .tdi(tdi), .tdo(tdo),
        .test_logic_reset(test_logic_reset), .run_test_idle(run_test_idle),
        .ir_is_user(ir_is_user), .capture_dr(capture_dr),
        .shift_dr(shift_dr), .update_dr(update_dr)
    );

    always #5 tck = ~tck;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_cmd_q[$];
    logic [31:0] word_q[$];
    logic [31:0] exp_rsp_q[$];
    int          rsp_cyc_q[$];

    int          cyc = 0;
    int          sh_cnt = 0;
    int          sd_cnt = 0;
    int          acc_cyc = 0;
    int          rsp_cnt = 0;
    logic        prev_ready = 1'b0;
    logic        prev_rsp = 1'b0;
    logic [7:0]  cmd_seen = '0;
    logic [31:0] cur_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Responder model and scoreboard monitor, sampled at negedge
    always @(negedge tck) begin
        cyc++;
        if (!rst_n) begin
            sh_cnt     = 0;
            prev_ready = 1'b0;
            prev_rsp   = 1'b0;
        end else begin
            if (prev_ready && !req_ready) begin
                acc_cyc = cyc;
                sd_cnt  = 0;
            end
            if (shift_dr) begin
                sd_cnt++;
                if (sh_cnt < 8) begin
                    cmd_seen[sh_cnt] = tdi;
                    if (sh_cnt == 7) begin
                        if (exp_cmd_q.size() == 0) check("unexpected_cmd", {24'h0, cmd_seen}, 32'hFFFF_FFFF);
                        else check("cmd_bits", {24'h0, cmd_seen}, {24'h0, exp_cmd_q.pop_front()});
                    end
                end else begin
                    if (sh_cnt == 8) begin
                        if (word_q.size() == 0) cur_word = '0;
                        else                    cur_word = word_q.pop_front();
                    end
                    if (sh_cnt < 40) tdo = cur_word[sh_cnt - 8];
                end
                sh_cnt++;
            end else begin
                tdo = 1'b0;
            end
            if (req_ready) sh_cnt = 0;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc_q.push_back(cyc);
                $display("[TB] rsp %0d data=0x%08h cycle=%0d", rsp_cnt, rsp_data, cyc);
                check("rsp_pulse_width", {31'h0, prev_rsp}, 32'h0);
                if (exp_rsp_q.size() == 0) check("unexpected_rsp", rsp_data, ~rsp_data);
                else check("rsp_data", rsp_data, exp_rsp_q.pop_front());
                check("rsp_latency", 32'(cyc - acc_cyc), 32'd50);
                check("shift_dr_cycles", 32'(sd_cnt), 32'd40);
            end
            prev_ready = req_ready;
            prev_rsp   = rsp_valid;
        end
    end

    task automatic check_reset_values();
        check("rst_tlr",   {31'h0, test_logic_reset}, 32'h1);
        check("rst_rti",   {31'h0, run_test_idle}, 32'h0);
        check("rst_shift", {31'h0, shift_dr}, 32'h0);
        check("rst_cap",   {31'h0, capture_dr}, 32'h0);
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_user",  {31'h0, ir_is_user}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h1);
        check("rst_rsp",   {31'h0, rsp_valid}, 32'h0);
        check("rst_data",  rsp_data, 32'h0);
    endtask

    // Release reset and count posedges until req_ready/ir_is_user rise
    task automatic release_and_init();
        int k = 0;
        @(negedge tck); #2;
        rst_n = 1'b1;
        while (k < 30) begin
            @(negedge tck); #1;
            k++;
            if (k == 1) check("init_rti", {31'h0, run_test_idle}, 32'h1);
            if (k == 12) check("init_ready_early", {31'h0, req_ready}, 32'h0);
            if (req_ready) break;
        end
        check("init_ready_edge", 32'(k), 32'd13);
        check("init_ir_user", {31'h0, ir_is_user}, 32'h1);
    endtask

    task automatic do_req(input logic [2:0] sel, input logic [7:0] cmd, input logic [31:0] word);
        int k = 0;
        @(negedge tck); #2;
        while (!req_ready && k < 100) begin
            @(negedge tck); #2;
            k++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        exp_cmd_q.push_back(cmd);
        word_q.push_back(word);
        exp_rsp_q.push_back(word);
        req_sel   = sel;
        req_valid = 1'b1;
        @(negedge tck); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int k = 0;
        while (rsp_cnt < target && k < budget) begin
            @(negedge tck); #2;
            k++;
        end
        check("rsp_count", 32'(rsp_cnt), 32'(target));
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_sel   = '0;

        // Reset state
        repeat (3) @(negedge tck);
        #2;
        check_reset_values();
        release_and_init();

        // Single transactions: cmd bits and readback word
        do_req(3'd7, 8'h97, 32'hA5C30F1E);
        wait_rsp(1, 200);
        do_req(3'd2, 8'h92, 32'h12345678);
        wait_rsp(2, 200);

        // Back-to-back with req_valid held high
        exp_cmd_q.push_back(8'h95); word_q.push_back(32'hDEADBEEF); exp_rsp_q.push_back(32'hDEADBEEF);
        exp_cmd_q.push_back(8'h95); word_q.push_back(32'h00000001); exp_rsp_q.push_back(32'h00000001);
        exp_cmd_q.push_back(8'h95); word_q.push_back(32'h80000000); exp_rsp_q.push_back(32'h80000000);
        @(negedge tck); #2;
        req_sel   = 3'd5;
        req_valid = 1'b1;
        wait_rsp(5, 400);
        req_valid = 1'b0;
        if (rsp_cyc_q.size() >= 5) begin
            check("b2b_gap_1", 32'(rsp_cyc_q[3] - rsp_cyc_q[2]), 32'd51);
            check("b2b_gap_2", 32'(rsp_cyc_q[4] - rsp_cyc_q[3]), 32'd51);
        end

        // req_valid / req_sel activity mid-transaction is ignored
        do_req(3'd3, 8'h93, 32'h0F0F00FF);
        repeat (5) @(negedge tck);
        #2;
        req_sel   = 3'd5;
        req_valid = 1'b1;
        @(negedge tck); #2;
        req_valid = 1'b0;
        wait_rsp(6, 200);
        repeat (60) @(negedge tck);
        #2;
        check("no_extra_rsp", 32'(rsp_cnt), 32'd6);
        check("queues_empty", 32'(exp_rsp_q.size() + exp_cmd_q.size()), 32'd0);

        // Reset in the middle of the readback scan
        do_req(3'd6, 8'h96, 32'hCAFEF00D);
        k = 0;
        while (sh_cnt < 19 && k < 200) begin
            @(negedge tck); #2;
            k++;
        end
        check("midrst_reached_rsh", {31'h0, shift_dr}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_cmd_q.delete();
        word_q.delete();
        exp_rsp_q.delete();
        repeat (3) @(negedge tck);
        release_and_init();
        check("midrst_no_rsp", 32'(rsp_cnt), 32'd6);
        do_req(3'd1, 8'h91, 32'h5A5A5A5A);
        wait_rsp(7, 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
